// File: rtl/rca_byte_serial_ctrl.sv
// Byte-serial adder/subtractor: one shared 8-bit ripple-carry adder processes an
// NBYTES-wide operand pair LSB byte first, chaining the carry through a register.
`timescale 1ns/1ps

module rca8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    always_comb begin
        logic c;
        s = '0;
        c = ci;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

module rca_byte_serial_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic [7:0]       rca_a;
    logic [7:0]       rca_b;
    logic [7:0]       rca_s;
    logic             rca_co;
    logic             accept;

    assign accept = (state == IDLE) && start;
    assign rca_a  = opa[{idx, 3'b000} +: 8];
    assign rca_b  = opb[{idx, 3'b000} +: 8];

    rca8 u_rca (
        .a  (rca_a),
        .b  (rca_b),
        .ci (carry),
        .s  (rca_s),
        .co (rca_co)
    );

    // Operand latches are pure data: loaded only on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa <= a;
            opb <= sub ? ~b : b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    sum[{idx, 3'b000} +: 8] <= rca_s;
                    carry                   <= rca_co;
                    if (idx == LAST) begin
                        // idx parks at 0 so it never leaves 0..NBYTES-1 for non-power-of-2 sizes.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        idx   <= '0;
                        cout  <= rca_co;
                        ovf   <= (opa[W-1] == opb[W-1]) && (rca_s[7] != opa[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca_byte_serial_ctrl.sv
// Self-checking bench: directed spec cases plus randomized requests scored against
// an arithmetic reference model with a cycle-count model of busy/done timing.
`timescale 1ns/1ps

module tb_rca_byte_serial_ctrl;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: cycles left until IDLE, and the expected {ovf,cout,sum}.
    int          remaining = 0;
    bit          has_res   = 1'b0;
    logic [63:0] cur_exp   = '0;

    rca_byte_serial_ctrl #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ovf, cout, sum}: unsigned result at W+1 bits, overflow from the true signed result.
    function automatic logic [63:0] model(input logic s, input logic c,
                                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        longint     sr;
        logic       o;
        if (s) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
            sr       = longint'($signed(x)) - longint'($signed(y));
        end else begin
            r  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        end
        o = (sr > SMAX) || (sr < SMIN);
        return 64'({o, r});
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= 0;
            has_res   <= 1'b0;
        end else if (remaining == 0) begin
            if (start) begin
                cur_exp   <= model(sub, cin, a, b);
                has_res   <= 1'b1;
                remaining <= NBYTES + 1;
            end
        end else begin
            remaining <= remaining - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 64'(busy), 64'(remaining >= 2));
            check("done", 64'(done), 64'(remaining == 1));
            if (remaining == 1)
                check("scoreboard", 64'({ovf, cout, sum}), cur_exp);
            else if (remaining == 0 && has_res)
                check("hold", 64'({ovf, cout, sum}), cur_exp);
            else if (remaining == 0)
                check("idle_zero", 64'({ovf, cout, sum}), 64'(0));
        end
    end

    task automatic do_op(input logic s, input logic c, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [63:0] exp, input string tag);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        sub = s; cin = c; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                check(tag, 64'({ovf, cout, sum}), exp);
            end
        end
        check("latency", 64'(lat), 64'(NBYTES + 1));
        check("busy_cycles", 64'(bcnt), 64'(NBYTES));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests, expected completion", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'({1'b0, 1'b1, 32'h0000_0000}), "add_wrap");
        do_op(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 64'({1'b0, 1'b0, 32'hFFFF_FFFE}), "sub_borrow");
        do_op(1'b1, 1'b1, 32'h0000_0007, 32'h0000_0005, 64'({1'b0, 1'b1, 32'h0000_0002}), "sub_noborrow");
        do_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 64'({1'b1, 1'b0, 32'h8000_0000}), "add_posovf");
        do_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'({1'b1, 1'b1, 32'h0000_0000}), "add_negovf");

        // Async reset mid-cycle while holding a nonzero result.
        #3 rst = 1'b1;
        #1 check("rst_async", 64'({busy, done, ovf, cout, sum}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // start held high with operands churning; only IDLE-cycle edges accept.
        sub = 1'b0; cin = 1'b1; a = 32'h0102_0304; b = 32'h1111_1111; start = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom;
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Abort at idx==2: no done pulse, outputs cleared.
        sub = 1'b0; cin = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst_idx2", 64'({busy, done, ovf, cout, sum}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        do_op(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 64'({1'b0, 1'b0, 32'h2345_678A}), "add_after_rst");

        for (int n = 0; n < 40; n++) begin
            logic         rs;
            logic         rc;
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            logic [W-1:0] edge_vals [4];
            edge_vals[0] = 32'h0000_0000;
            edge_vals[1] = 32'hFFFF_FFFF;
            edge_vals[2] = 32'h7FFF_FFFF;
            edge_vals[3] = 32'h8000_0000;
            repeat ($urandom_range(0, 2)) begin
                a = $urandom; b = $urandom;
                @(posedge clk); #1;
            end
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rx = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
            ry = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
            do_op(rs, rc, rx, ry, model(rs, rc, rx, ry), "rand");
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
